cache_line_arbiter: RTL and testbench
=====================================

Name: cache_line_arbiter

Overview:
- Shares one lower-level 256-bit line port (the cacheline adaptor's LLC side) between an instruction cache (read-only) and a data cache (read/write).
- Serves exactly one line transaction at a time.
- Latches the winner's command and address at grant time, routes the memory response back to the winner only, and alternates grants round-robin when both caches contend.

Parameters:
- ADDR_W, 32, address width on all ports
- LINE_W, 256, cache line width on all data ports

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_address  in  ADDR_W  I-cache line address
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_address  in  ADDR_W  D-cache line address
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_address  out  ADDR_W  to adaptor address_i
- mem_read  out  1  to adaptor read_i
- mem_write  out  1  to adaptor write_i
- mem_wdata  out  LINE_W  to adaptor line_i
- mem_rdata  in  LINE_W  from adaptor line_o
- mem_resp  in  1  from adaptor resp_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = ARB_IDLE, last_grant = REQ_I.
  - Latched address, op and wdata = 0.
  - All outputs 0: mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata.
- States:
  - ARB_IDLE:
    - mem_read = mem_write = 0.
    - Evaluate requests: i_req = i_read, d_req = d_read | d_write.
    - Only one requester active: grant it.
    - Both active: grant the one that is not last_grant.
    - On grant, at the next edge: latch the address; latch op (READ if d_read, else WRITE; d_read wins if d_read and d_write are both high); latch d_wdata for a D write; update last_grant; go to ARB_SERVE_I or ARB_SERVE_D.
  - ARB_SERVE_I / ARB_SERVE_D:
    - mem_address, mem_read, mem_write and mem_wdata are driven from the latched registers. Requester inputs are ignored once latched.
    - mem_resp = 1 in the same cycle: the winner's resp = 1 (combinational pass-through); the other resp stays 0. Next state is ARB_RELEASE.
    - Otherwise stay in the serve state.
  - ARB_RELEASE:
    - mem_read = mem_write = 0, both resps 0. Lasts exactly one cycle, then ARB_IDLE.
    - Gives the adaptor time to return to its idle state and the requester time to drop its request.
- Timing: request seen in ARB_IDLE at cycle N → mem_read/mem_write high at N+1. mem_resp at cycle M → resp to winner at M, ARB_RELEASE at M+1, ARB_IDLE at M+2. Earliest next grant command is at M+3.
- Read data: i_rdata = d_rdata = mem_rdata (broadcast, unregistered). Valid only in the cycle the corresponding resp is high.
- Write-back: mem_wdata is held constant from grant until ARB_RELEASE, even if d_wdata changes.
- Boundary conditions:
  - mem_resp while in ARB_IDLE or ARB_RELEASE: ignored, no resp generated.
  - Requester deasserts mid-service: the transaction still completes and the resp pulse is still issued.
  - A request arriving during serve or ARB_RELEASE waits; it is not dropped.
  - Back-to-back contention alternates strictly I, D, I, D… No starvation: the maximum wait is one foreign transaction.
  - rst mid-serve: return to ARB_IDLE on the next edge and drop all outputs. rst is the shared system reset, so the adaptor resets with it.
  - No resp is ever high for both requesters in the same cycle.

Decomposition:
- Package cache_arb_pkg:
  - arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_RELEASE}
  - req_id_t {REQ_I, REQ_D}
  - mem_op_t {OP_READ, OP_WRITE}
  - Constants LINE_W = 256, ADDR_W = 32
- Sub-module arb_rr_picker: two-input round-robin choice. Inputs: i_req, d_req, last_grant. Outputs: grant_valid, grant_id. Purely combinational; the last_grant register stays in the top module.

Test Plan:
- I-only read: i_read = 1, i_address = 0x0000_1000; mem_resp pulsed 10 cycles after mem_read → mem_read high at N+1 with mem_address 0x1000; i_resp high exactly once; i_rdata = mem_rdata = 0xDEAD…BEEF in that cycle; d_resp stays 0.
- D write-back: d_write = 1, d_address = 0x0000_2040, d_wdata = pattern A; d_wdata changed to pattern B one cycle after grant → mem_write = 1 and mem_wdata = A throughout; d_resp pulses once; mem_write = 0 in ARB_RELEASE.
- Simultaneous after reset: i_read and d_read both high at the same edge → D served first (last_grant reset = I), then I. Order: d_resp, then i_resp; mem_address sequence is D address, then I address.
- Sustained contention, 6 transactions with both requesters re-asserting immediately → grant order D, I, D, I, D, I; at least one cycle with mem_read = mem_write = 0 between transactions.
- Spurious and conflicting inputs: mem_resp = 1 while in ARB_IDLE → no resp output. d_read = d_write = 1 → mem_read = 1, mem_write = 0.
- Reset mid-serve: rst asserted 3 cycles into an I read → next cycle all outputs 0, state ARB_IDLE. A new d_read after rst deasserts is granted normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache line arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : which cache owns the line port
//   mem_op_t    : latched line operation
package cache_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-input round-robin choice between the I-cache and D-cache requests.
// Purely combinational; the caller owns the last_grant register.
//   i_req       : I-cache wants the line port
//   d_req       : D-cache wants the line port
//   last_grant  : requester served most recently
//   grant_valid : at least one request is present
//   grant_id    : requester to serve next (meaningful only with grant_valid)
module arb_rr_picker
  import cache_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_id    = REQ_I;
    if (i_req && d_req) begin
      // Contention: hand the port to whoever did not have it last.
      grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant_id = REQ_D;
    end
  end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares one 256-bit line port to the cacheline adaptor between the I-cache
// (read only) and the D-cache (read / write-back). One transaction at a time;
// the winner's command, address and write data are latched at grant, the
// memory response is routed back to the winner only, and contention is
// resolved round-robin.
//   clk, rst                 : clock, synchronous active-high reset
//   i_address/i_read         : I-cache line read request
//   i_rdata/i_resp           : I-cache returned line and completion pulse
//   d_address/d_read/d_write : D-cache line request
//   d_wdata                  : D-cache write-back line
//   d_rdata/d_resp           : D-cache returned line and completion pulse
//   mem_*                    : adaptor side (address_i, read_i, write_i,
//                              line_i, line_o, resp_o)
module cache_line_arbiter #(
  parameter int unsigned ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int unsigned LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  import cache_arb_pkg::arb_state_t;
  import cache_arb_pkg::req_id_t;
  import cache_arb_pkg::mem_op_t;
  import cache_arb_pkg::ARB_IDLE;
  import cache_arb_pkg::ARB_SERVE_I;
  import cache_arb_pkg::ARB_SERVE_D;
  import cache_arb_pkg::ARB_RELEASE;
  import cache_arb_pkg::REQ_I;
  import cache_arb_pkg::REQ_D;
  import cache_arb_pkg::OP_READ;
  import cache_arb_pkg::OP_WRITE;

  arb_state_t        r_state;
  req_id_t           r_last_grant;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_address;
  logic [LINE_W-1:0] r_wdata;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_valid;
  req_id_t           w_grant_id;
  logic              w_serving;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  arb_rr_picker u_picker (
    .i_req       (w_i_req),
    .d_req       (w_d_req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= REQ_I;
      r_op         <= OP_READ;
      r_address    <= '0;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_last_grant <= w_grant_id;
            if (w_grant_id == REQ_D) begin
              r_address <= d_address;
              r_state   <= ARB_SERVE_D;
              // A read wins when the D-cache raises read and write together.
              if (d_read) begin
                r_op <= OP_READ;
              end else begin
                r_op    <= OP_WRITE;
                r_wdata <= d_wdata;
              end
            end else begin
              r_address <= i_address;
              r_op      <= OP_READ;
              r_state   <= ARB_SERVE_I;
            end
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (mem_resp) begin
            r_state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          // One dead cycle lets the adaptor go idle and the winner drop its request.
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign w_serving = (r_state == ARB_SERVE_I) || (r_state == ARB_SERVE_D);

  // Command side comes only from latched state; requester inputs are ignored
  // for the remainder of the transaction.
  assign mem_address = r_address;
  assign mem_wdata   = r_wdata;
  assign mem_read    = w_serving && (r_op == OP_READ);
  assign mem_write   = w_serving && (r_op == OP_WRITE);

  // Completion is a same-cycle pass-through of mem_resp, gated to the winner;
  // a stray mem_resp in idle or release never reaches either cache.
  assign i_resp  = (r_state == ARB_SERVE_I) && mem_resp;
  assign d_resp  = (r_state == ARB_SERVE_D) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
module tb_cache_line_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [LW-1:0] BEEF  = {8{32'hDEADBEEF}};
  localparam logic [LW-1:0] PAT_A = {8{32'hA5A50F0F}};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_address, d_address, mem_address;
  logic          i_read, d_read, d_write, i_resp, d_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_line_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_address   (i_address),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_address   (d_address),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  // id: 0 = I-cache, 1 = D-cache
  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    bit            wr;
    logic [LW-1:0] wdata;
    int            start;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rst_q = 1'b0;
  exp_t          exp_q[$];
  int            obs_order[$];
  int            i_cnt = 0;
  int            d_cnt = 0;
  logic [LW-1:0] last_i_rdata = '0;
  exp_t          cur;
  bit            cur_valid = 1'b0;
  bit            rsp_en = 1'b0;
  int            rsp_delay = -1;
  bit            rsp_fixed_data = 1'b0;
  int            rsp_d;
  // reference model state
  bit            m_busy = 1'b0;
  bit            m_gap = 1'b0;
  int            m_last = 0;
  exp_t          m_e;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: the port is either free, busy with one transaction, or in
  // its one-cycle cool-down after a response. When free, any waiting cache is
  // served; if both wait, the one not served most recently goes first.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_q = rst;
      if (rst) begin
        m_busy = 1'b0;
        m_gap  = 1'b0;
        m_last = 0;
        exp_q.delete();
      end else if (m_busy) begin
        if (mem_resp) begin
          m_busy = 1'b0;
          m_gap  = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (i_read || d_read || d_write) begin
        if (i_read && (d_read || d_write)) m_e.id = 1 - m_last;
        else m_e.id = i_read ? 0 : 1;
        m_e.addr  = (m_e.id == 1) ? d_address : i_address;
        m_e.wr    = (m_e.id == 1) && !d_read;
        m_e.wdata = d_wdata;
        m_e.start = cyc;
        exp_q.push_back(m_e);
        m_busy = 1'b1;
        m_last = m_e.id;
      end
    end
  end

  // Monitor: compares the DUT against the expected transactions every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        cur_valid = 1'b0;
        chk("reset_ctrl", LW'({mem_read, mem_write, i_resp, d_resp}), '0);
        chk("reset_addr", LW'(mem_address), '0);
        chk("reset_wdata", mem_wdata, '0);
      end else begin
        if (!cur_valid && exp_q.size() > 0 && exp_q[0].start == cyc) begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
        end
        if (!cur_valid) begin
          chk("idle_quiet", LW'({mem_read, mem_write, i_resp, d_resp}), '0);
        end else begin
          chk("mem_address", LW'(mem_address), LW'(cur.addr));
          chk("mem_read", LW'(mem_read), LW'(!cur.wr));
          chk("mem_write", LW'(mem_write), LW'(cur.wr));
          if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
          if (mem_resp) begin
            chk("i_resp", LW'(i_resp), LW'(cur.id == 0));
            chk("d_resp", LW'(d_resp), LW'(cur.id == 1));
            if (cur.id == 0) chk("i_rdata", i_rdata, mem_rdata);
            else chk("d_rdata", d_rdata, mem_rdata);
            if (i_resp) begin
              i_cnt++;
              last_i_rdata = i_rdata;
              obs_order.push_back(0);
            end
            if (d_resp) begin
              d_cnt++;
              obs_order.push_back(1);
            end
            cur_valid = 1'b0;
          end else begin
            chk("resp_early", LW'({i_resp, d_resp}), '0);
          end
        end
      end
    end
  end

  // Adaptor stand-in: answers each command after 1 + rsp_d cycles.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rsp_en && (mem_read || mem_write)) begin
        rsp_d = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 4));
        repeat (rsp_d) @(posedge clk);
        @(posedge clk); #1;
        mem_resp  = 1'b1;
        mem_rdata = rsp_fixed_data ? BEEF : rand_line();
        @(posedge clk); #1;
        mem_resp  = 1'b0;
        mem_rdata = rand_line();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic i_txn(input logic [AW-1:0] a);
    int n;
    @(posedge clk); #1;
    i_read    = 1'b1;
    i_address = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_resp && n < 500);
    chk("i_done", LW'(i_resp), LW'(1));
    @(posedge clk); #1;
    i_read    = 1'b0;
    i_address = $urandom();
  endtask

  task automatic d_txn(input logic [AW-1:0] a, input bit rd, input bit wr,
                       input logic [LW-1:0] wd, input bit chg);
    int n;
    @(posedge clk); #1;
    d_read    = rd;
    d_write   = wr;
    d_address = a;
    d_wdata   = wd;
    if (chg) begin
      @(posedge clk); #1;
      d_wdata = ~wd;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_resp && n < 500);
    chk("d_done", LW'(d_resp), LW'(1));
    @(posedge clk); #1;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_wdata = rand_line();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_order(input string nm, input int want[$]);
    chk({nm, "_len"}, LW'(obs_order.size()), LW'(want.size()));
    for (int k = 0; k < want.size(); k++) begin
      chk(nm, LW'(k < obs_order.size() ? obs_order[k] : -1), LW'(want[k]));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // I-only read, response 10 cycles after the command
    rsp_en = 1'b1; rsp_delay = 9; rsp_fixed_data = 1'b1;
    i_cnt = 0; d_cnt = 0;
    i_txn(32'h0000_1000);
    repeat (3) @(posedge clk);
    chk("t1_i_count", LW'(i_cnt), LW'(1));
    chk("t1_d_count", LW'(d_cnt), LW'(0));
    chk("t1_rdata", last_i_rdata, BEEF);

    // D write-back, write data changed after grant
    rsp_delay = 3; rsp_fixed_data = 1'b0;
    i_cnt = 0; d_cnt = 0;
    d_txn(32'h0000_2040, 1'b0, 1'b1, PAT_A, 1'b1);
    repeat (3) @(posedge clk);
    chk("t2_d_count", LW'(d_cnt), LW'(1));
    chk("t2_i_count", LW'(i_cnt), LW'(0));

    // Simultaneous after reset: D first, then I
    do_reset();
    obs_order.delete();
    rsp_delay = 2;
    fork
      i_txn(32'h0000_3000);
      d_txn(32'h0000_4000, 1'b1, 1'b0, '0, 1'b0);
    join
    chk_order("t3_order", '{1, 0});

    // Sustained contention
    do_reset();
    obs_order.delete();
    rsp_delay = -1;
    fork
      begin
        for (int k = 0; k < 3; k++) i_txn($urandom());
      end
      begin
        for (int k = 0; k < 3; k++) begin
          n = int'($urandom_range(0, 2));
          d_txn($urandom(), n == 0, n != 0, rand_line(), 1'b0);
        end
      end
    join
    chk_order("t4_order", '{1, 0, 1, 0, 1, 0});

    // Spurious mem_resp in idle, then D read+write together
    repeat (2) @(posedge clk);
    rsp_en = 1'b0; i_cnt = 0; d_cnt = 0;
    @(posedge clk); #1; mem_resp = 1'b1;
    @(posedge clk); #1; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    chk("t5_spurious", LW'(i_cnt + d_cnt), LW'(0));
    rsp_en = 1'b1;
    d_txn(32'h0000_5080, 1'b1, 1'b1, rand_line(), 1'b0);

    // Reset three cycles into an I read, then a normal D read
    rsp_en = 1'b0; i_cnt = 0;
    @(posedge clk); #1;
    i_read = 1'b1; i_address = 32'h0000_6000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_read && n < 50);
    chk("t6_started", LW'(mem_read), LW'(1));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_read = 1'b0;
    repeat (2) @(posedge clk);
    chk("t6_no_i_resp", LW'(i_cnt), LW'(0));
    rsp_en = 1'b1; rsp_delay = 1;
    obs_order.delete();
    d_txn(32'h0000_7000, 1'b1, 1'b0, '0, 1'b0);
    chk_order("t6_order", '{1});

    // Randomized traffic
    rsp_delay = -1;
    fork
      begin
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_txn($urandom());
        end
      end
      begin
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          n = int'($urandom_range(0, 3));
          d_txn($urandom(), n == 0 || n == 3, n != 0, rand_line(), n[0]);
        end
      end
    join

    repeat (5) @(posedge clk);
    chk("sb_empty", LW'(exp_q.size()), LW'(0));
    chk("no_inflight", LW'(cur_valid), LW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
